// File: rtl/jtag_uart_encode.sv
// jtag_uart_encode
//   Transmit-side framing for the JTAG UART. Accepts payload bytes and command
//   codes, applies 0xFE escape framing and writes the resulting byte stream to
//   the UART DATA register. Before writing, it polls the CONTROL register for
//   WSPACE so that the UART FIFO is never overrun.
//
// Ports
//   iCLK, iRST            clock; asynchronous active-high reset
//   oJTAG_SLAVE_ADDR      Avalon address (0 = DATA, 1 = CONTROL)
//   oJTAG_SLAVE_RDREQ     Avalon read request (CONTROL poll)
//   iJTAG_SLAVE_RDDATA    Avalon read data, WSPACE in [31:16]
//   oJTAG_SLAVE_WRREQ     Avalon write request (DATA)
//   oJTAG_SLAVE_WRDATA    Avalon write data {24'd0, byte}
//   iJTAG_SLAVE_WAIT      Avalon waitrequest
//   iTX_DATA/CMD/VALID    input word: byte, command flag, valid
//   oTX_READY             input word accepted when iTX_VALID && oTX_READY
//   oBUSY                 bytes pending or bus request in progress
//   oTX_COUNT             wire bytes written, modulo 2^16
module jtag_uart_encode #(
    parameter int unsigned POLL_GAP = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oJTAG_SLAVE_ADDR,
    output logic        oJTAG_SLAVE_RDREQ,
    input  logic [31:0] iJTAG_SLAVE_RDDATA,
    output logic        oJTAG_SLAVE_WRREQ,
    output logic [31:0] oJTAG_SLAVE_WRDATA,
    input  logic        iJTAG_SLAVE_WAIT,
    input  logic [7:0]  iTX_DATA,
    input  logic        iTX_CMD,
    input  logic        iTX_VALID,
    output logic        oTX_READY,
    output logic        oBUSY,
    output logic [15:0] oTX_COUNT
);

    localparam logic [7:0]  ESC      = 8'hFE;
    localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POLL,
        ST_BACKOFF,
        ST_WRITE
    } state_t;

    state_t      state;
    logic [7:0]  pend_head;
    logic [7:0]  pend_tail;
    logic [1:0]  pend_cnt;
    logic [15:0] credit;
    logic [15:0] gap;

    logic        accept;
    logic        two_byte;
    logic [15:0] credit_dec;
    logic [15:0] wspace;
    logic        rddata_unused;

    assign accept     = iTX_VALID && oTX_READY;
    // Commands and a literal 0xFE both go out as an escape pair; the second
    // byte of the pair is always the input byte itself.
    assign two_byte   = iTX_CMD || (iTX_DATA == ESC);
    assign credit_dec = credit - 16'd1;
    assign wspace     = iJTAG_SLAVE_RDDATA[31:16];
    // Low half of CONTROL (interrupt enables/flags) is not needed here.
    assign rddata_unused = ^iJTAG_SLAVE_RDDATA[15:0];

    assign oTX_READY = (state == ST_IDLE) && (pend_cnt == 2'd0);
    assign oBUSY     = (pend_cnt != 2'd0) || (state != ST_IDLE);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state              <= ST_IDLE;
            pend_head          <= '0;
            pend_tail          <= '0;
            pend_cnt           <= '0;
            credit             <= '0;
            gap                <= '0;
            oTX_COUNT          <= '0;
            oJTAG_SLAVE_ADDR   <= 1'b0;
            oJTAG_SLAVE_RDREQ  <= 1'b0;
            oJTAG_SLAVE_WRREQ  <= 1'b0;
            oJTAG_SLAVE_WRDATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (two_byte) begin
                            pend_head <= ESC;
                            pend_tail <= iTX_DATA;
                            pend_cnt  <= 2'd2;
                        end else begin
                            pend_head <= iTX_DATA;
                            pend_cnt  <= 2'd1;
                        end
                    end else if (pend_cnt != 2'd0) begin
                        if (credit != 16'd0) begin
                            state              <= ST_WRITE;
                            oJTAG_SLAVE_ADDR   <= 1'b0;
                            oJTAG_SLAVE_WRREQ  <= 1'b1;
                            oJTAG_SLAVE_WRDATA <= {24'd0, pend_head};
                        end else begin
                            state             <= ST_POLL;
                            oJTAG_SLAVE_ADDR  <= 1'b1;
                            oJTAG_SLAVE_RDREQ <= 1'b1;
                        end
                    end
                end

                ST_POLL: begin
                    if (!iJTAG_SLAVE_WAIT) begin
                        credit            <= wspace;
                        oJTAG_SLAVE_RDREQ <= 1'b0;
                        oJTAG_SLAVE_ADDR  <= 1'b0;
                        if (wspace == 16'd0) begin
                            state <= ST_BACKOFF;
                            gap   <= GAP_LOAD;
                        end else begin
                            state              <= ST_WRITE;
                            oJTAG_SLAVE_WRREQ  <= 1'b1;
                            oJTAG_SLAVE_WRDATA <= {24'd0, pend_head};
                        end
                    end
                end

                ST_BACKOFF: begin
                    if (gap == 16'd0) begin
                        state             <= ST_POLL;
                        oJTAG_SLAVE_ADDR  <= 1'b1;
                        oJTAG_SLAVE_RDREQ <= 1'b1;
                    end else begin
                        gap <= gap - 16'd1;
                    end
                end

                ST_WRITE: begin
                    if (!iJTAG_SLAVE_WAIT) begin
                        oTX_COUNT <= oTX_COUNT + 16'd1;
                        credit    <= credit_dec;
                        pend_head <= pend_tail;
                        pend_cnt  <= pend_cnt - 2'd1;
                        if (pend_cnt == 2'd2) begin
                            if (credit_dec != 16'd0) begin
                                oJTAG_SLAVE_WRDATA <= {24'd0, pend_tail};
                            end else begin
                                state              <= ST_POLL;
                                oJTAG_SLAVE_WRREQ  <= 1'b0;
                                oJTAG_SLAVE_WRDATA <= '0;
                                oJTAG_SLAVE_ADDR   <= 1'b1;
                                oJTAG_SLAVE_RDREQ  <= 1'b1;
                            end
                        end else begin
                            state              <= ST_IDLE;
                            oJTAG_SLAVE_WRREQ  <= 1'b0;
                            oJTAG_SLAVE_WRDATA <= '0;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_uart_encode.sv
module tb_jtag_uart_encode;

    localparam int unsigned POLL_GAP = 16;

    logic        clk;
    logic        rst;
    logic        addr;
    logic        rdreq;
    logic [31:0] rddata;
    logic        wrreq;
    logic [31:0] wrdata;
    logic        slv_wait;
    logic [7:0]  tx_data;
    logic        tx_cmd;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] tx_count;

    jtag_uart_encode #(.POLL_GAP(POLL_GAP)) dut (
        .iCLK               (clk),
        .iRST               (rst),
        .oJTAG_SLAVE_ADDR   (addr),
        .oJTAG_SLAVE_RDREQ  (rdreq),
        .iJTAG_SLAVE_RDDATA (rddata),
        .oJTAG_SLAVE_WRREQ  (wrreq),
        .oJTAG_SLAVE_WRDATA (wrdata),
        .iJTAG_SLAVE_WAIT   (slv_wait),
        .iTX_DATA           (tx_data),
        .iTX_CMD            (tx_cmd),
        .iTX_VALID          (tx_valid),
        .oTX_READY          (tx_ready),
        .oBUSY              (busy),
        .oTX_COUNT          (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rd;
        logic [7:0] d;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] wspace_q[$];

    int total = 0;
    int bad   = 0;
    int hold_cfg = 0;
    int gap_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_write(input logic [7:0] b);
        txn_t t;
        t.rd = 1'b0;
        t.d  = b;
        exp_q.push_back(t);
    endtask

    task automatic push_read();
        txn_t t;
        t.rd = 1'b1;
        t.d  = 8'h00;
        exp_q.push_back(t);
    endtask

    // Avalon slave model and transaction monitor
    bit          in_req = 0;
    bit          prev_wait = 0;
    bit          gap_arm = 0;
    int          hold_left = 0;
    int          hold_used = 0;
    int          req_cycles = 0;
    int          idle_cnt = 0;
    logic        p_addr, p_rd, p_wr;
    logic [31:0] p_data;
    txn_t        got;
    logic [15:0] ws;

    always @(negedge clk) begin
        if (rst) begin
            slv_wait  = 1'b0;
            rddata    = '0;
            in_req    = 0;
            prev_wait = 0;
            gap_arm   = 0;
            hold_left = 0;
        end else begin
            rddata = '0;
            if (rdreq || wrreq)
                check("req_exclusive", {31'd0, rdreq & wrreq}, 32'd0);
            if (prev_wait) begin
                check("hold_addr",   {31'd0, addr},  {31'd0, p_addr});
                check("hold_rdreq",  {31'd0, rdreq}, {31'd0, p_rd});
                check("hold_wrreq",  {31'd0, wrreq}, {31'd0, p_wr});
                check("hold_wrdata", wrdata, p_data);
            end
            if ((rdreq || wrreq) && !in_req) begin
                in_req     = 1;
                req_cycles = 0;
                hold_left  = wrreq ? hold_cfg : 0;
                hold_used  = hold_left;
            end
            if (gap_arm) begin
                if (rdreq || wrreq) begin
                    check("backoff_gap", idle_cnt, POLL_GAP);
                    gap_seen++;
                    gap_arm = 0;
                end else begin
                    idle_cnt++;
                end
            end
            if (rdreq || wrreq) req_cycles++;
            if ((rdreq || wrreq) && hold_left > 0) begin
                slv_wait = 1'b1;
                hold_left--;
            end else begin
                slv_wait = 1'b0;
            end
            if ((rdreq || wrreq) && !slv_wait) begin
                // transfer completes on the coming rising edge
                in_req = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_txn", {rdreq, 23'd0, wrdata[7:0]}, 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    check("txn_kind", {31'd0, rdreq}, {31'd0, got.rd});
                    if (got.rd) begin
                        check("read_addr", {31'd0, addr}, 32'd1);
                    end else begin
                        check("write_addr", {31'd0, addr}, 32'd0);
                        check("write_data", wrdata, {24'd0, got.d});
                        check("write_cycles", req_cycles, 1 + hold_used);
                    end
                end
                if (rdreq) begin
                    if (wspace_q.size() == 0) begin
                        check("wspace_supply", 32'd0, 32'd1);
                        ws = 16'd0;
                    end else begin
                        ws = wspace_q.pop_front();
                    end
                    rddata = {ws, 16'h0000};
                    if (ws == 16'd0) begin
                        gap_arm  = 1;
                        idle_cnt = 0;
                    end
                end
            end
            prev_wait = slv_wait && (rdreq || wrreq);
            p_addr = addr;
            p_rd   = rdreq;
            p_wr   = wrreq;
            p_data = wrdata;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        wspace_q.delete();
        hold_cfg = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns #1 after the accepting rising edge.
    task automatic send(input logic [7:0] d, input logic c);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) check("send_timeout", 32'd0, 32'd1);
        tx_data  = d;
        tx_cmd   = c;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"},   {31'd0, addr},     32'd0);
        check({tag, "_rdreq"},  {31'd0, rdreq},    32'd0);
        check({tag, "_wrreq"},  {31'd0, wrreq},    32'd0);
        check({tag, "_wrdata"}, wrdata,            32'd0);
        check({tag, "_ready"},  {31'd0, tx_ready}, 32'd1);
        check({tag, "_busy"},   {31'd0, busy},     32'd0);
        check({tag, "_count"},  {16'd0, tx_count}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        tx_data  = '0;
        tx_cmd   = 1'b0;
        tx_valid = 1'b0;

        // reset and idle
        do_reset();
        repeat (20) @(negedge clk);
        check_idle_outputs("reset");

        // poll then single write, second byte reuses credit
        wspace_q.push_back(16'h0040);
        push_read();
        push_write(8'h41);
        send(8'h41, 1'b0);
        drain("drain_41");
        check("count_41", {16'd0, tx_count}, 32'd1);
        push_write(8'h42);
        send(8'h42, 1'b0);
        @(posedge clk); #1;
        check("t42_wrreq_n1", {31'd0, wrreq}, 32'd1);
        check("t42_data_n1", wrdata, 32'h0000_0042);
        @(posedge clk); #1;
        check("t42_wrreq_n2", {31'd0, wrreq}, 32'd0);
        check("t42_count_n2", {16'd0, tx_count}, 32'd2);
        drain("drain_42");

        // escape framing: literal FE then command 00
        do_reset();
        wspace_q.push_back(16'h0040);
        push_read();
        push_write(8'hFE);
        push_write(8'hFE);
        send(8'hFE, 1'b0);
        check("fe_ready_low", {31'd0, tx_ready}, 32'd0);
        push_write(8'hFE);
        push_write(8'h00);
        send(8'h00, 1'b1);
        check("cmd_ready_n0", {31'd0, tx_ready}, 32'd0);
        @(posedge clk); #1;
        check("cmd_wrreq_n1", {31'd0, wrreq}, 32'd1);
        check("cmd_data_n1", wrdata, 32'h0000_00FE);
        @(posedge clk); #1;
        check("cmd_wrreq_n2", {31'd0, wrreq}, 32'd1);
        check("cmd_data_n2", wrdata, 32'h0000_0000);
        check("cmd_ready_n2", {31'd0, tx_ready}, 32'd0);
        @(posedge clk); #1;
        check("cmd_wrreq_n3", {31'd0, wrreq}, 32'd0);
        check("cmd_ready_n3", {31'd0, tx_ready}, 32'd1);
        drain("drain_esc");
        check("count_esc", {16'd0, tx_count}, 32'd4);

        // zero WSPACE backoff, credit of one splitting an escape pair
        do_reset();
        gap_seen = 0;
        wspace_q.push_back(16'h0000);
        wspace_q.push_back(16'h0001);
        wspace_q.push_back(16'h0001);
        push_read();
        push_read();
        push_write(8'hFE);
        push_read();
        push_write(8'h01);
        send(8'h01, 1'b1);
        drain("drain_backoff");
        check("gap_seen", gap_seen, 32'd1);
        check("count_backoff", {16'd0, tx_count}, 32'd2);

        // waitrequest held during a write
        do_reset();
        hold_cfg = 3;
        wspace_q.push_back(16'h0040);
        push_read();
        push_write(8'h55);
        send(8'h55, 1'b0);
        drain("drain_wait");
        check("count_wait", {16'd0, tx_count}, 32'd1);

        // reset with the second escape byte pending
        do_reset();
        hold_cfg = 6;
        wspace_q.push_back(16'h0040);
        push_read();
        push_write(8'hFE);
        push_write(8'h33);
        send(8'h33, 1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!(tx_count == 16'd1 && wrreq) && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("pre_rst_count", {16'd0, tx_count}, 32'd1);
        check("pre_rst_data", wrdata, 32'h0000_0033);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        exp_q.delete();
        wspace_q.delete();
        hold_cfg = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_idle_outputs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
